// File: rtl/voting_pkg.sv
// Shared definitions for the ballot arbiter: FSM state codes, candidate codes
// and default sizing.
package voting_pkg;

  localparam int unsigned NUM_BOOTHS_DEF  = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARB    = 3'd1,
    ISSUE  = 3'd2,
    HOLD   = 3'd3,
    CLOSED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAND_NONE = 2'b00,
    CAND_1    = 2'b01,
    CAND_2    = 2'b10,
    CAND_3    = 2'b11
  } cand_e;

  function automatic logic cand_valid(input logic [1:0] code);
    return code != CAND_NONE;
  endfunction

endpackage

// File: rtl/ballot_arbiter_if.sv
// Booth, tally and session signals of the ballot arbiter; the arbiter uses the
// slave modport, the booth/tally side uses master.
interface ballot_arbiter_if #(
  parameter int unsigned NUM_BOOTHS = voting_pkg::NUM_BOOTHS_DEF
);

  logic                    session_open;
  logic                    session_close;
  logic [NUM_BOOTHS-1:0]   booth_req;
  logic [2*NUM_BOOTHS-1:0] booth_cand;
  logic [NUM_BOOTHS-1:0]   booth_ack;
  logic [NUM_BOOTHS-1:0]   booth_reject;
  logic                    tally_valid;
  logic [1:0]              tally_cand;
  logic                    tally_ready;
  logic                    results_latch;
  logic [31:0]             votes_cast;
  logic [2:0]              state;

  modport master (
    output session_open, session_close, booth_req, booth_cand, tally_ready,
    input  booth_ack, booth_reject, tally_valid, tally_cand, results_latch,
           votes_cast, state
  );

  modport slave (
    input  session_open, session_close, booth_req, booth_cand, tally_ready,
    output booth_ack, booth_reject, tally_valid, tally_cand, results_latch,
           votes_cast, state
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around; one-hot grant, all-zero when nothing is requested.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  int unsigned   idx;
  logic [PW-1:0] sel;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ballot_arbiter.sv
// Shares one tally unit between NUM_BOOTHS voting booths: round-robin grant,
// invalid-code rejection, per-booth lockout and a post-vote hold period.
module ballot_arbiter
  import voting_pkg::*;
#(
  parameter int unsigned NUM_BOOTHS  = NUM_BOOTHS_DEF,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input logic             clk,
  input logic             rst,
  ballot_arbiter_if.slave bus
);

  localparam int unsigned PW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         idx_q, idx_d;
  logic [NUM_BOOTHS-1:0] lock_q, lock_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  close_pend_q, close_pend_d;
  logic [31:0]           votes_q, votes_d;
  logic                  valid_q, valid_d;
  logic [1:0]            cand_q, cand_d;
  logic [NUM_BOOTHS-1:0] ack_q, ack_d;
  logic [NUM_BOOTHS-1:0] rej_q, rej_d;
  logic                  latch_q, latch_d;

  logic [NUM_BOOTHS-1:0] eligible;
  logic [NUM_BOOTHS-1:0] grant;
  logic [PW-1:0]         gnt_idx;
  logic [1:0]            gnt_code;
  logic [NUM_BOOTHS-1:0] iss_oh;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
    return (32'(g) == NUM_BOOTHS - 1) ? '0 : g + PW'(1);
  endfunction

  // A booth whose reject is on the wire this cycle still holds its request
  // until it sees the pulse, so it is kept out of arbitration for that cycle.
  assign eligible = bus.booth_req & ~lock_q & ~rej_q;

  rr_arbiter #(
    .N  (NUM_BOOTHS),
    .PW (PW)
  ) u_rr (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (grant)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_code = CAND_NONE;
    for (int unsigned i = 0; i < NUM_BOOTHS; i++) begin
      if (grant[i]) begin
        gnt_idx  = PW'(i);
        gnt_code = bus.booth_cand[2*i +: 2];
      end
    end
  end

  always_comb begin
    iss_oh         = '0;
    iss_oh[idx_q]  = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    close_pend_d = close_pend_q;
    votes_d      = votes_q;
    valid_d      = valid_q;
    cand_d       = cand_q;
    ack_d        = '0;
    rej_d        = '0;
    lock_d       = lock_q & bus.booth_req;

    unique case (state_q)
      IDLE: begin
        if (bus.session_close) begin
          state_d = CLOSED;
        end else if (bus.session_open) begin
          state_d = ARB;
          votes_d = '0;
        end
      end
      ARB: begin
        if (bus.session_close) begin
          state_d = CLOSED;
        end else if (|grant) begin
          if (cand_valid(gnt_code)) begin
            state_d = ISSUE;
            valid_d = 1'b1;
            cand_d  = gnt_code;
            idx_d   = gnt_idx;
          end else begin
            rej_d = grant;
            ptr_d = ptr_after(gnt_idx);
          end
        end
      end
      ISSUE: begin
        if (bus.session_close) close_pend_d = 1'b1;
        if (bus.tally_ready) begin
          valid_d      = 1'b0;
          cand_d       = CAND_NONE;
          ack_d        = iss_oh;
          lock_d       = lock_d | iss_oh;
          ptr_d        = ptr_after(idx_q);
          votes_d      = (votes_q == '1) ? votes_q : votes_q + 32'd1;
          hold_d       = '0;
          close_pend_d = 1'b0;
          state_d      = (close_pend_q || bus.session_close) ? CLOSED : HOLD;
        end
      end
      HOLD: begin
        if (bus.session_close) begin
          state_d = CLOSED;
          hold_d  = '0;
        end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d = ARB;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      CLOSED: begin
        if (bus.session_open && !bus.session_close) begin
          state_d = ARB;
          votes_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    latch_d = (state_d == CLOSED) && (state_q != CLOSED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      lock_q       <= '0;
      hold_q       <= '0;
      close_pend_q <= 1'b0;
      votes_q      <= '0;
      valid_q      <= 1'b0;
      cand_q       <= CAND_NONE;
      ack_q        <= '0;
      rej_q        <= '0;
      latch_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      lock_q       <= lock_d;
      hold_q       <= hold_d;
      close_pend_q <= close_pend_d;
      votes_q      <= votes_d;
      valid_q      <= valid_d;
      cand_q       <= cand_d;
      ack_q        <= ack_d;
      rej_q        <= rej_d;
      latch_q      <= latch_d;
    end
  end

  assign bus.booth_ack     = ack_q;
  assign bus.booth_reject  = rej_q;
  assign bus.tally_valid   = valid_q;
  assign bus.tally_cand    = cand_q;
  assign bus.results_latch = latch_q;
  assign bus.votes_cast    = votes_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_ballot_arbiter.sv
// Bench for ballot_arbiter: directed session scenarios, then random booth
// agents checked against a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_ballot_arbiter;
  import voting_pkg::*;

  localparam int NB = 4;
  localparam int HC = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ballot_arbiter_if #(.NUM_BOOTHS(NB)) bif ();

  ballot_arbiter #(
    .NUM_BOOTHS  (NB),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bif.session_open  = 1'b0;
    bif.session_close = 1'b0;
    bif.booth_req     = '0;
    bif.booth_cand    = '0;
    bif.tally_ready   = 1'b0;
  endtask

  task automatic set_booth(input int b, input logic r, input logic [1:0] c);
    bif.booth_req[b]        = r;
    bif.booth_cand[2*b +: 2] = c;
  endtask

  task automatic reset_dut();
    drive_idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic pulse_open();
    bif.session_open = 1'b1;
    step();
    bif.session_open = 1'b0;
    check("open_state", 32'(bif.state), 32'(ARB));
    check("open_votes", bif.votes_cast, 0);
  endtask

  task automatic wait_hold(output int n);
    n = 0;
    while (bif.state == HOLD && n < 100) begin
      step();
      n++;
    end
  endtask

  function automatic int pick(input bit [NB-1:0] p, input int from);
    for (int k = 0; k < NB; k++)
      if (p[(from + k) % NB]) return (from + k) % NB;
    return -1;
  endfunction

  int          n;
  int          m_ptr, win, next_dec;
  int unsigned m_votes;
  bit          in_issue, rdy;
  bit [NB-1:0] waiting, pend;
  logic [1:0]  code [NB];
  int          cool [NB];
  int unsigned n_latch;

  initial begin
    drive_idle();
    rst = 1'b0;
    step();
    step();
    check("rst_state", 32'(bif.state), 32'(IDLE));
    check("rst_votes", bif.votes_cast, 0);
    check("rst_valid", bif.tally_valid, 0);
    check("rst_cand", bif.tally_cand, 0);
    check("rst_ack", bif.booth_ack, 0);
    check("rst_rej", bif.booth_reject, 0);
    check("rst_latch", bif.results_latch, 0);
    rst = 1'b1;

    // Single vote from booth 2, then a full hold period.
    pulse_open();
    set_booth(2, 1'b1, 2'b10);
    bif.tally_ready = 1'b1;
    step();
    check("t1_valid", bif.tally_valid, 1);
    check("t1_cand", bif.tally_cand, 2);
    check("t1_state", 32'(bif.state), 32'(ISSUE));
    step();
    check("t1_ack", bif.booth_ack, 4);
    check("t1_votes", bif.votes_cast, 1);
    check("t1_valid_off", bif.tally_valid, 0);
    set_booth(2, 1'b0, 2'b00);
    wait_hold(n);
    check("t1_hold_len", n, HC);
    check("t1_arb", 32'(bif.state), 32'(ARB));

    // Booths 0 and 3 together from pointer 0.
    reset_dut();
    pulse_open();
    bif.tally_ready = 1'b1;
    set_booth(0, 1'b1, 2'b01);
    set_booth(3, 1'b1, 2'b11);
    step();
    check("t2_cand_first", bif.tally_cand, 1);
    step();
    check("t2_ack_first", bif.booth_ack, 1);
    set_booth(0, 1'b0, 2'b00);
    wait_hold(n);
    check("t2_hold_len", n, HC);
    step();
    check("t2_valid_second", bif.tally_valid, 1);
    check("t2_cand_second", bif.tally_cand, 3);
    step();
    check("t2_ack_second", bif.booth_ack, 8);
    check("t2_votes", bif.votes_cast, 2);
    set_booth(3, 1'b0, 2'b00);
    wait_hold(n);

    // Held request votes once; drop and reassert votes again.
    set_booth(1, 1'b1, 2'b01);
    step();
    check("t3_valid1", bif.tally_valid, 1);
    step();
    check("t3_ack1", bif.booth_ack, 2);
    check("t3_votes1", bif.votes_cast, 3);
    wait_hold(n);
    repeat (6) begin
      step();
      check("t3_locked_valid", bif.tally_valid, 0);
      check("t3_locked_ack", bif.booth_ack, 0);
    end
    set_booth(1, 1'b0, 2'b01);
    step();
    set_booth(1, 1'b1, 2'b01);
    step();
    check("t3_valid2", bif.tally_valid, 1);
    step();
    check("t3_ack2", bif.booth_ack, 2);
    check("t3_votes2", bif.votes_cast, 4);
    set_booth(1, 1'b0, 2'b00);
    wait_hold(n);

    // Invalid code is rejected.
    set_booth(0, 1'b1, 2'b00);
    step();
    check("t4_rej", bif.booth_reject, 1);
    check("t4_valid", bif.tally_valid, 0);
    check("t4_votes", bif.votes_cast, 4);
    set_booth(0, 1'b0, 2'b00);
    step();
    check("t4_rej_clear", bif.booth_reject, 0);
    check("t4_state", 32'(bif.state), 32'(ARB));

    // Stalled tally with close during ISSUE.
    bif.tally_ready = 1'b0;
    set_booth(3, 1'b1, 2'b10);
    step();
    check("t5_valid", bif.tally_valid, 1);
    bif.session_close = 1'b1;
    step();
    bif.session_close = 1'b0;
    check("t5_state_issue", 32'(bif.state), 32'(ISSUE));
    repeat (4) begin
      step();
      check("t5_stall_valid", bif.tally_valid, 1);
      check("t5_stall_cand", bif.tally_cand, 2);
    end
    bif.tally_ready = 1'b1;
    step();
    check("t5_ack", bif.booth_ack, 8);
    check("t5_votes", bif.votes_cast, 5);
    check("t5_closed", 32'(bif.state), 32'(CLOSED));
    check("t5_latch", bif.results_latch, 1);
    set_booth(3, 1'b0, 2'b00);
    step();
    check("t5_latch_once", bif.results_latch, 0);
    set_booth(2, 1'b1, 2'b01);
    repeat (3) begin
      step();
      check("t5_closed_ignore", bif.tally_valid, 0);
    end
    set_booth(2, 1'b0, 2'b00);

    // Reset in the middle of ISSUE.
    pulse_open();
    bif.tally_ready = 1'b0;
    set_booth(1, 1'b1, 2'b11);
    step();
    check("t6_valid", bif.tally_valid, 1);
    rst = 1'b0;
    step();
    check("t6_valid_rst", bif.tally_valid, 0);
    check("t6_cand_rst", bif.tally_cand, 0);
    check("t6_ack_rst", bif.booth_ack, 0);
    check("t6_state_rst", 32'(bif.state), 32'(IDLE));
    check("t6_votes_rst", bif.votes_cast, 0);
    rst = 1'b1;
    set_booth(1, 1'b0, 2'b00);
    step();
    check("t6_no_ack", bif.booth_ack, 0);

    // Open and close together in IDLE: close wins.
    bif.session_open  = 1'b1;
    bif.session_close = 1'b1;
    step();
    bif.session_open  = 1'b0;
    bif.session_close = 1'b0;
    check("t7_closed", 32'(bif.state), 32'(CLOSED));
    check("t7_latch", bif.results_latch, 1);
    step();
    check("t7_latch_once", bif.results_latch, 0);

    // Random booth agents against a round-robin transaction model.
    reset_dut();
    pulse_open();
    m_ptr    = 0;
    m_votes  = 0;
    next_dec = 1;
    in_issue = 1'b0;
    win      = 0;
    waiting  = '0;
    for (int b = 0; b < NB; b++) begin
      code[b] = 2'b00;
      cool[b] = 0;
    end
    for (int s = 1; s <= 3000; s++) begin
      for (int b = 0; b < NB; b++) begin
        if (!waiting[b]) begin
          if (cool[b] > 0) cool[b]--;
          else if ($urandom_range(0, 3) == 0) begin
            waiting[b] = 1'b1;
            code[b]    = 2'($urandom_range(0, 3));
            set_booth(b, 1'b1, code[b]);
          end
        end
      end
      bif.tally_ready = ($urandom_range(0, 2) != 0);
      pend = waiting;
      rdy  = bif.tally_ready;
      step();
      check("r_ack_rej_excl", 32'(|bif.booth_ack && |bif.booth_reject), 0);
      check("r_ack_onehot", 32'($onehot0(bif.booth_ack)), 1);
      check("r_rej_onehot", 32'($onehot0(bif.booth_reject)), 1);
      if (in_issue) begin
        if (rdy) begin
          check("r_ack", bif.booth_ack, 32'(1) << win);
          check("r_votes", bif.votes_cast, m_votes + 1);
          check("r_valid_drop", bif.tally_valid, 0);
          m_votes++;
          in_issue = 1'b0;
          next_dec = s + HC + 1;
        end else begin
          check("r_stall_valid", bif.tally_valid, 1);
          check("r_stall_cand", bif.tally_cand, code[win]);
          check("r_stall_ack", bif.booth_ack, 0);
        end
      end else if (s >= next_dec && pend != 0) begin
        win   = pick(pend, m_ptr);
        m_ptr = (win + 1) % NB;
        if (code[win] == 2'b00) begin
          check("r_reject", bif.booth_reject, 32'(1) << win);
          check("r_reject_valid", bif.tally_valid, 0);
          next_dec = s + 1;
        end else begin
          check("r_grant_valid", bif.tally_valid, 1);
          check("r_grant_cand", bif.tally_cand, code[win]);
          check("r_grant_rej", bif.booth_reject, 0);
          in_issue = 1'b1;
        end
      end else begin
        check("r_quiet_valid", bif.tally_valid, 0);
        check("r_quiet_rej", bif.booth_reject, 0);
        check("r_quiet_ack", bif.booth_ack, 0);
      end
      for (int b = 0; b < NB; b++) begin
        if (waiting[b] && (bif.booth_ack[b] || bif.booth_reject[b])) begin
          waiting[b] = 1'b0;
          cool[b]    = $urandom_range(1, 4);
          set_booth(b, 1'b0, 2'b00);
        end
      end
    end

    bif.tally_ready   = 1'b1;
    bif.session_close = 1'b1;
    step();
    bif.session_close = 1'b0;
    n_latch = 32'(bif.results_latch);
    repeat (30) begin
      step();
      n_latch += 32'(bif.results_latch);
    end
    check("r_close_state", 32'(bif.state), 32'(CLOSED));
    check("r_latch_count", n_latch, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
